// File: rtl/axi_stream_to_bram_pkg.sv
// Shared definitions for the luma frame-capture path: FSM encoding and default frame geometry.
package axi_stream_to_bram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SOF,
    CAPTURE,
    FLUSH,
    DONE
  } state_t;

  localparam int unsigned BEATS_PER_LINE  = 40;
  localparam int unsigned LINES_PER_FRAME = 240;
  localparam int unsigned FRAME_WORDS     = BEATS_PER_LINE * LINES_PER_FRAME;

endpackage

// File: rtl/axi_stream_to_bram_frame_counter.sv
// Column/line position tracker for a captured frame; produces the BRAM word address.
module axis_frame_counter
  import axi_stream_to_bram_pkg::*;
#(
  parameter int unsigned beats_per_line  = BEATS_PER_LINE,
  parameter int unsigned lines_per_frame = LINES_PER_FRAME
) (
  input  logic        ACLK,
  input  logic        rst,
  input  logic        clear,
  input  logic        restart,
  input  logic        inc,
  input  logic        force_eol,
  output logic [31:0] word_addr,
  output logic        last_beat,
  output logic        end_of_line
);

  localparam int unsigned CW = (beats_per_line > 1) ? $clog2(beats_per_line) : 1;
  localparam int unsigned LW = (lines_per_frame > 1) ? $clog2(lines_per_frame) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(beats_per_line - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(lines_per_frame - 1);

  logic [CW-1:0] col;
  logic [LW-1:0] line;

  always_comb begin
    end_of_line = (col == COL_LAST);
    last_beat   = end_of_line && (line == LINE_LAST);
    word_addr   = 32'(line) * 32'(beats_per_line) + 32'(col);
  end

  // restart means the current beat took word 0, so the next beat lands on column 1
  always_ff @(posedge ACLK or negedge rst) begin
    if (!rst) begin
      col  <= '0;
      line <= '0;
    end else if (clear) begin
      col  <= '0;
      line <= '0;
    end else if (restart) begin
      col  <= CW'(1);
      line <= '0;
    end else if (inc) begin
      if (end_of_line || force_eol) begin
        col  <= '0;
        line <= (line == LINE_LAST) ? '0 : line + LW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/axi_stream_to_bram.sv
// AXI4-Stream video sink packing 8 luma bytes per beat into sequential BRAM words.
// Define SYNC_CHECK_EN to enable TLAST/TUSER framing checks and the sync_error flag.
module axi_stream_to_bram
  import axi_stream_to_bram_pkg::*;
#(
  parameter int unsigned n               = 24,
  parameter int unsigned i               = 1,
  parameter int unsigned d               = 1,
  parameter int unsigned u               = 1,
  parameter int unsigned pixel_per_clk   = 8,
  parameter int unsigned num_brams       = 1,
  parameter int unsigned addr_width      = 14,
  parameter int unsigned beats_per_line  = BEATS_PER_LINE,
  parameter int unsigned lines_per_frame = LINES_PER_FRAME
) (
  input  logic                                   ACLK,
  input  logic                                   rst,
  input  logic [8*n-1:0]                         s_TDATA,
  input  logic                                   s_TVALID,
  output logic                                   s_TREADY,
  input  logic [u-1:0]                           s_TUSER,
  input  logic                                   s_TLAST,
  input  logic [n-1:0]                           s_TKEEP,
  input  logic [n-1:0]                           s_TSTRB,
  input  logic [i-1:0]                           s_TID,
  input  logic [d-1:0]                           s_TDEST,
  output logic [num_brams-1:0]                   bram_we,
  output logic [num_brams*addr_width-1:0]        bram_addr,
  output logic [num_brams*pixel_per_clk*8-1:0]   bram_data_in,
  input  logic [num_brams*pixel_per_clk*8-1:0]   bram_data_out,
  input  logic                                   capture_enable,
  output logic                                   capture_done_irq,
  output logic                                   sync_error
);

`ifdef SYNC_CHECK_EN
  localparam bit SYNC_EN = 1'b1;
`else
  localparam bit SYNC_EN = 1'b0;
`endif

  state_t state, next_state;

  logic        cnt_clear, cnt_restart, cnt_inc, cnt_eol;
  logic        wr_en, wr_zero, arm, err;
  logic [31:0] word_addr;
  logic        last_beat, end_of_line;
  logic [pixel_per_clk*8-1:0] luma;

  logic                       we_r;
  logic [addr_width-1:0]      addr_r;
  logic [pixel_per_clk*8-1:0] data_r;

  axis_frame_counter #(
    .beats_per_line (beats_per_line),
    .lines_per_frame(lines_per_frame)
  ) u_counter (
    .ACLK       (ACLK),
    .rst        (rst),
    .clear      (cnt_clear),
    .restart    (cnt_restart),
    .inc        (cnt_inc),
    .force_eol  (cnt_eol),
    .word_addr  (word_addr),
    .last_beat  (last_beat),
    .end_of_line(end_of_line)
  );

  always_comb begin
    luma = '0;
    for (int unsigned b = 0; b < pixel_per_clk; b++)
      luma[b*8 +: 8] = s_TDATA[b*24 +: 8];
  end

  always_ff @(posedge ACLK or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state       = state;
    s_TREADY         = 1'b0;
    capture_done_irq = 1'b0;
    cnt_clear        = 1'b0;
    cnt_restart      = 1'b0;
    cnt_inc          = 1'b0;
    cnt_eol          = 1'b0;
    wr_en            = 1'b0;
    wr_zero          = 1'b0;
    arm              = 1'b0;
    err              = 1'b0;
    case (state)
      IDLE: begin
        cnt_clear = 1'b1;
        if (capture_enable) begin
          arm        = 1'b1;
          next_state = WAIT_SOF;
        end
      end
      WAIT_SOF: begin
        s_TREADY = 1'b1;
        if (s_TVALID && s_TUSER[0]) begin
          wr_en       = 1'b1;
          wr_zero     = 1'b1;
          cnt_restart = 1'b1;
          next_state  = CAPTURE;
        end
      end
      CAPTURE: begin
        s_TREADY = 1'b1;
        if (s_TVALID) begin
          wr_en = 1'b1;
          // a mid-frame SOF overrides any TLAST check on the same beat
          if (SYNC_EN && s_TUSER[0]) begin
            wr_zero     = 1'b1;
            cnt_restart = 1'b1;
            err         = 1'b1;
          end else begin
            cnt_inc = 1'b1;
            cnt_eol = SYNC_EN && s_TLAST;
            err     = SYNC_EN && (s_TLAST != end_of_line);
            if (last_beat) next_state = FLUSH;
          end
        end
      end
      FLUSH: next_state = DONE;
      DONE: begin
        capture_done_irq = 1'b1;
        next_state       = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge rst) begin
    if (!rst) begin
      we_r   <= 1'b0;
      addr_r <= '0;
      data_r <= '0;
    end else begin
      we_r <= wr_en;
      if (wr_en) begin
        addr_r <= wr_zero ? '0 : word_addr[addr_width-1:0];
        data_r <= luma;
      end
    end
  end

`ifdef SYNC_CHECK_EN
  logic sync_error_r;
  always_ff @(posedge ACLK or negedge rst) begin
    if (!rst)     sync_error_r <= 1'b0;
    else if (arm) sync_error_r <= 1'b0;
    else if (err) sync_error_r <= 1'b1;
  end
  assign sync_error = sync_error_r;
`else
  assign sync_error = 1'b0;
`endif

  assign bram_we      = {num_brams{we_r}};
  assign bram_addr    = {num_brams{addr_r}};
  assign bram_data_in = {num_brams{data_r}};

  logic unused_ok;
  assign unused_ok = ^{s_TKEEP, s_TSTRB, s_TID, s_TDEST, s_TUSER, s_TLAST, bram_data_out,
                       word_addr, end_of_line, arm, err};

endmodule

// File: tb/tb_axi_stream_to_bram.sv
// Scoreboard bench for axi_stream_to_bram: directed frames with expected writes queued at accept time.
module tb_axi_stream_to_bram;
  import axi_stream_to_bram_pkg::*;

`ifdef SYNC_CHECK_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  logic         ACLK = 1'b0;
  logic         rst = 1'b0;
  logic [191:0] s_TDATA = '0;
  logic         s_TVALID = 1'b0;
  logic         s_TREADY;
  logic [0:0]   s_TUSER = '0;
  logic         s_TLAST = 1'b0;
  logic [23:0]  s_TKEEP = '1;
  logic [23:0]  s_TSTRB = '1;
  logic [0:0]   s_TID = '0;
  logic [0:0]   s_TDEST = '0;
  logic [0:0]   bram_we;
  logic [13:0]  bram_addr;
  logic [63:0]  bram_data_in;
  logic [63:0]  bram_data_out = '0;
  logic         capture_enable = 1'b0;
  logic         capture_done_irq;
  logic         sync_error;

  axi_stream_to_bram dut (
    .ACLK(ACLK), .rst(rst),
    .s_TDATA(s_TDATA), .s_TVALID(s_TVALID), .s_TREADY(s_TREADY),
    .s_TUSER(s_TUSER), .s_TLAST(s_TLAST), .s_TKEEP(s_TKEEP), .s_TSTRB(s_TSTRB),
    .s_TID(s_TID), .s_TDEST(s_TDEST),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_data_in(bram_data_in),
    .bram_data_out(bram_data_out),
    .capture_enable(capture_enable), .capture_done_irq(capture_done_irq),
    .sync_error(sync_error)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [13:0] addr;
    logic [63:0] data;
  } wr_t;

  wr_t q[$];
  int  checks = 0, errors = 0, writes = 0, accepts = 0, irqs = 0;

  function automatic logic [63:0] luma(input int k);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[b*8 +: 8] = 8'((k * 8 + b) & 255);
    return r;
  endfunction

  always @(negedge ACLK) begin
    wr_t e;
    if (capture_done_irq) irqs++;
    if (bram_we[0]) begin
      writes++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $error("FAIL unexpected_write observed addr=%0d, none expected", bram_addr);
      end else begin
        e = q.pop_front();
        assert (bram_addr === e.addr && bram_data_in === e.data) else begin
          errors++;
          $error("FAIL write observed addr=%0d data=%h expected addr=%0d data=%h",
                 bram_addr, bram_data_in, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic summary_and_finish();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  endtask

  task automatic send_beat(input int k, input bit tu, input bit tl, input bit gaps,
                           input bit push, input int ea);
    int t;
    wr_t e;
    logic [191:0] dat;
    if (gaps && $urandom_range(0, 3) == 0) begin
      @(negedge ACLK);
      s_TVALID = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge ACLK);
    end
    @(negedge ACLK);
    for (int b = 0; b < 24; b++) dat[b*8 +: 8] = 8'($urandom);
    for (int b = 0; b < 8; b++) dat[b*24 +: 8] = 8'((k * 8 + b) & 255);
    s_TDATA  = dat;
    s_TUSER  = tu;
    s_TLAST  = tl;
    s_TVALID = 1'b1;
    t = 0;
    while (!s_TREADY && t < 100) begin
      @(negedge ACLK);
      t++;
    end
    checks++;
    assert (t < 100) else begin
      errors++;
      $error("FAIL accept_timeout observed tready=%0b expected 1 within 100 cycles", s_TREADY);
      summary_and_finish();
    end
    if (push) begin
      e.addr = 14'(ea);
      e.data = luma(k);
      q.push_back(e);
      accepts++;
    end
    @(posedge ACLK);
  endtask

  task automatic arm();
    @(negedge ACLK);
    capture_enable = 1'b1;
    @(negedge ACLK);
    capture_enable = 1'b0;
    check("armed_tready", 64'(s_TREADY), 64'd1);
    check("armed_sync_clear", 64'(sync_error), 64'd0);
  endtask

  task automatic run_frame(input bit gaps, input int early_at, input int sof_at, input int abort_at);
    int a, k;
    bit tu, tl;
    a = 0;
    k = 0;
    writes = 0;
    accepts = 0;
    irqs = 0;
    while (a < int'(FRAME_WORDS)) begin
      tu = (k == 0) || (k == sof_at);
      tl = (a % BEATS_PER_LINE == BEATS_PER_LINE - 1) || (k == early_at);
      if (SYNC && k == sof_at) a = 0;
      send_beat(k, tu, tl, gaps, 1'b1, a);
      if (k == early_at || k == sof_at) begin
        #1;
        check("sync_error_set", 64'(sync_error), 64'(SYNC));
      end
      if (SYNC && k == early_at) a = (a / BEATS_PER_LINE + 1) * BEATS_PER_LINE;
      else a++;
      k++;
      if (k == abort_at) return;
    end
  endtask

  task automatic finish_frame(input bit exp_err);
    @(negedge ACLK);
    s_TVALID = 1'b0;
    check("irq_flush", 64'(capture_done_irq), 64'd0);
    check("tready_flush", 64'(s_TREADY), 64'd0);
    @(negedge ACLK);
    check("irq_done", 64'(capture_done_irq), 64'd1);
    @(negedge ACLK);
    check("irq_after", 64'(capture_done_irq), 64'd0);
    check("tready_idle", 64'(s_TREADY), 64'd0);
    check("irq_count", 64'(irqs), 64'd1);
    check("queue_empty", 64'(q.size()), 64'd0);
    check("writes_eq_accepts", 64'(writes), 64'(accepts));
    check("sync_error_end", 64'(sync_error), 64'(exp_err));
  endtask

  initial begin
    #12;
    check("rst_tready", 64'(s_TREADY), 64'd0);
    check("rst_we", 64'(bram_we), 64'd0);
    check("rst_addr", 64'(bram_addr), 64'd0);
    check("rst_data", bram_data_in, 64'd0);
    check("rst_irq", 64'(capture_done_irq), 64'd0);
    check("rst_sync", 64'(sync_error), 64'd0);
    @(negedge ACLK);
    rst = 1'b1;

    // clean frame preceded by five non-SOF beats that must be dropped
    arm();
    for (int j = 0; j < 5; j++) send_beat(1000 + j, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_frame(1'b0, -1, -1, -1);
    finish_frame(1'b0);
    check("frame1_writes", 64'(writes), 64'(FRAME_WORDS));

    arm();
    run_frame(1'b1, -1, -1, -1);
    finish_frame(1'b0);
    check("frame2_writes", 64'(writes), 64'(FRAME_WORDS));

    // early TLAST at line 3 column 20
    arm();
    run_frame(1'b0, 3 * BEATS_PER_LINE + 20, -1, -1);
    finish_frame(SYNC);

    // SOF reasserted at beat 500
    arm();
    run_frame(1'b0, -1, 500, -1);
    finish_frame(SYNC);
    check("frame4_writes", 64'(writes), 64'(SYNC ? FRAME_WORDS + 500 : FRAME_WORDS));

    // reset at beat 3000, then a clean re-armed frame
    arm();
    run_frame(1'b0, -1, -1, 3000);
    @(negedge ACLK);
    #2;
    rst = 1'b0;
    s_TVALID = 1'b0;
    #1;
    check("mid_rst_tready", 64'(s_TREADY), 64'd0);
    check("mid_rst_we", 64'(bram_we), 64'd0);
    check("mid_rst_addr", 64'(bram_addr), 64'd0);
    check("mid_rst_data", bram_data_in, 64'd0);
    check("mid_rst_irq", 64'(capture_done_irq), 64'd0);
    check("mid_rst_queue", 64'(q.size()), 64'd0);
    @(negedge ACLK);
    rst = 1'b1;
    @(negedge ACLK);
    check("post_rst_we", 64'(bram_we), 64'd0);
    check("post_rst_tready", 64'(s_TREADY), 64'd0);
    arm();
    run_frame(1'b0, -1, -1, -1);
    finish_frame(1'b0);
    check("frame6_writes", 64'(writes), 64'(FRAME_WORDS));

    summary_and_finish();
  end

endmodule
